// File: rtl/ac_motor_ramp_ctrl.sv
// Run/direction/target sequencer for the AC motor driver: rate-limited frequency ramp,
// V/f amplitude, dead-timed reversal and latched overcurrent fault with cooldown.
module ac_motor_ramp_ctrl #(
    parameter int DEAD_TIME = 1000,
    parameter int OC_COUNT  = 4,
    parameter int COOLDOWN  = 50000,
    parameter int AMP_BOOST = 64,
    parameter int AMP_SHIFT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        dir_req,
    input  logic [11:0] freq_target,
    input  logic [15:0] ramp_div,
    input  logic [11:0] adc,
    input  logic [11:0] adc_cmp,
    input  logic        adc_latch,
    input  logic        fault_clr,
    output logic        enable,
    output logic        cw,
    output logic        ccw,
    output logic [11:0] frequency,
    output logic [11:0] amplitude,
    output logic [2:0]  state,
    output logic        fault,
    output logic        at_speed
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RAMP     = 3'd1,
        RUN      = 3'd2,
        STOPPING = 3'd3,
        DEAD     = 3'd4,
        FAULT    = 3'd5
    } state_t;

    localparam int DEAD_W = $clog2(DEAD_TIME + 1) + 1;
    localparam int COOL_W = $clog2(COOLDOWN + 1) + 1;
    localparam int OC_W   = $clog2(OC_COUNT + 1) + 1;
    localparam int AMP_W  = 19 + AMP_SHIFT;

    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'((DEAD_TIME > 0) ? DEAD_TIME - 1 : 0);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
    localparam logic [OC_W-1:0]   OC_LIM    = OC_W'((OC_COUNT > 0) ? OC_COUNT : 1);
    localparam logic [AMP_W-1:0]  AMP_MAX   = AMP_W'(4095);

    state_t            state_reg, state_next;
    logic              dir_reg, dir_next;
    logic [11:0]       freq_reg, freq_next;
    logic [11:0]       amp_reg, amp_next;
    logic [15:0]       pre_reg, pre_next;
    logic [DEAD_W-1:0] dead_reg, dead_next;
    logic [COOL_W-1:0] cool_reg, cool_next;
    logic [OC_W-1:0]   oc_reg, oc_next;
    logic              latch_d_reg;

    logic              ramping;
    logic              driving;
    logic              tick;
    logic              stop_req;
    logic              latch_rise;
    logic              oc_trip;
    logic [15:0]       div_last;
    logic [AMP_W-1:0]  amp_sum;

    assign ramping    = (state_reg == RAMP) || (state_reg == STOPPING);
    assign driving    = ramping || (state_reg == RUN);
    assign div_last   = (ramp_div == 16'd0) ? 16'd0 : ramp_div - 16'd1;
    // >= rather than == so a ramp_div shrink mid-count cannot skip the terminal count
    assign tick       = ramping && (pre_reg >= div_last);
    assign stop_req   = !run || (freq_target == 12'd0) || (dir_req != dir_reg);
    assign latch_rise = adc_latch && !latch_d_reg;
    assign amp_sum    = AMP_W'(AMP_BOOST) + (AMP_W'(freq_reg) << AMP_SHIFT);

    always_comb begin
        oc_next = oc_reg;
        if (!driving) begin
            oc_next = '0;
        end else if (latch_rise) begin
            if (adc > adc_cmp) begin
                oc_next = (oc_reg >= OC_LIM) ? oc_reg : oc_reg + OC_W'(1);
            end else begin
                oc_next = '0;
            end
        end
    end

    assign oc_trip = driving && (oc_next >= OC_LIM);

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        freq_next  = freq_reg;
        case (state_reg)
            IDLE: begin
                freq_next = 12'd0;
                if (run && (freq_target != 12'd0)) begin
                    state_next = RAMP;
                    dir_next   = dir_req;
                end
            end
            RAMP: begin
                if (stop_req) begin
                    state_next = STOPPING;
                end else if (freq_reg == freq_target) begin
                    state_next = RUN;
                end else if (tick) begin
                    freq_next = (freq_reg < freq_target) ? freq_reg + 12'd1 : freq_reg - 12'd1;
                end
            end
            RUN: begin
                if (stop_req) begin
                    state_next = STOPPING;
                end else if (freq_target != freq_reg) begin
                    state_next = RAMP;
                end
            end
            STOPPING: begin
                if (freq_reg == 12'd0) begin
                    state_next = DEAD;
                end else if (tick) begin
                    freq_next = freq_reg - 12'd1;
                end
            end
            DEAD: begin
                freq_next = 12'd0;
                if (dead_reg >= DEAD_LAST) begin
                    state_next = IDLE;
                end
            end
            FAULT: begin
                freq_next = 12'd0;
                if ((cool_reg >= COOL_LAST) && fault_clr && !run) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                freq_next  = 12'd0;
            end
        endcase
        // Overcurrent beats every other transition, including a pending stop
        if (oc_trip) begin
            state_next = FAULT;
            freq_next  = 12'd0;
        end
    end

    always_comb begin
        pre_next = 16'd0;
        if ((state_next == state_reg) && ramping) begin
            pre_next = tick ? 16'd0 : pre_reg + 16'd1;
        end
        dead_next = ((state_reg == DEAD) && (state_next == DEAD)) ? dead_reg + DEAD_W'(1) : '0;
        cool_next = '0;
        if (state_reg == FAULT) begin
            cool_next = (cool_reg >= COOL_LAST) ? cool_reg : cool_reg + COOL_W'(1);
        end
        // Amplitude trails frequency by one cycle but drops at once on fault entry
        if ((freq_reg == 12'd0) || (state_next == FAULT)) begin
            amp_next = 12'd0;
        end else if (amp_sum > AMP_MAX) begin
            amp_next = 12'hFFF;
        end else begin
            amp_next = amp_sum[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            dir_reg     <= 1'b0;
            freq_reg    <= 12'd0;
            amp_reg     <= 12'd0;
            pre_reg     <= 16'd0;
            dead_reg    <= '0;
            cool_reg    <= '0;
            oc_reg      <= '0;
            latch_d_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dir_reg     <= dir_next;
            freq_reg    <= freq_next;
            amp_reg     <= amp_next;
            pre_reg     <= pre_next;
            dead_reg    <= dead_next;
            cool_reg    <= cool_next;
            oc_reg      <= oc_next;
            latch_d_reg <= adc_latch;
        end
    end

    assign enable    = driving;
    assign cw        = driving && !dir_reg;
    assign ccw       = driving && dir_reg;
    assign frequency = freq_reg;
    assign amplitude = amp_reg;
    assign state     = state_reg;
    assign fault     = (state_reg == FAULT);
    assign at_speed  = (state_reg == RUN);

endmodule

// File: tb/tb_ac_motor_ramp_ctrl.sv
// Bench for ac_motor_ramp_ctrl: directed vector table, hand-written fault sequences and
// randomized stimulus checked every cycle against a behavioural model.
module tb_ac_motor_ramp_ctrl;

    localparam int DT    = 1000;
    localparam int OCN   = 4;
    localparam int CD    = 200;
    localparam int BOOST = 64;
    localparam int SHIFT = 0;

    logic        clk = 1'b0;
    logic        reset_n, run, dir_req, adc_latch, fault_clr;
    logic [11:0] freq_target, adc, adc_cmp;
    logic [15:0] ramp_div;
    logic        enable, cw, ccw, fault, at_speed;
    logic [11:0] frequency, amplitude;
    logic [2:0]  state;

    always #5 clk = ~clk;

    ac_motor_ramp_ctrl #(
        .DEAD_TIME(DT), .OC_COUNT(OCN), .COOLDOWN(CD), .AMP_BOOST(BOOST), .AMP_SHIFT(SHIFT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .dir_req(dir_req),
        .freq_target(freq_target), .ramp_div(ramp_div), .adc(adc), .adc_cmp(adc_cmp),
        .adc_latch(adc_latch), .fault_clr(fault_clr), .enable(enable), .cw(cw), .ccw(ccw),
        .frequency(frequency), .amplitude(amplitude), .state(state), .fault(fault),
        .at_speed(at_speed)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Behavioural model: state as a plain number, advanced once per clock from the rules
    int m_state, m_freq, m_amp, m_dir, m_pre, m_dead, m_cool, m_oc, m_latd;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        int ns, nf, na, noc, div_eff;
        bit moving, rise, tick, stop;
        if (!reset_n) begin
            m_state = 0; m_freq = 0; m_amp = 0; m_dir = 0; m_pre = 0;
            m_dead = 0; m_cool = 0; m_oc = 0; m_latd = 0;
        end else begin
            moving  = (m_state >= 1 && m_state <= 3);
            rise    = adc_latch && !m_latd;
            noc     = m_oc;
            if (!moving) noc = 0;
            else if (rise) noc = (adc > adc_cmp) ? ((m_oc + 1 > OCN) ? OCN : m_oc + 1) : 0;
            div_eff = (ramp_div == 0) ? 1 : int'(ramp_div);
            tick    = (m_state == 1 || m_state == 3) && (m_pre >= div_eff - 1);
            stop    = !run || freq_target == 0 || int'(dir_req) != m_dir;
            ns = m_state;
            nf = m_freq;
            if (m_state == 0) begin
                if (run && freq_target != 0) begin ns = 1; m_dir = int'(dir_req); end
            end else if (m_state == 1) begin
                if (stop) ns = 3;
                else if (m_freq == int'(freq_target)) ns = 2;
                else if (tick) nf = (m_freq < int'(freq_target)) ? m_freq + 1 : m_freq - 1;
            end else if (m_state == 2) begin
                if (stop) ns = 3;
                else if (m_freq != int'(freq_target)) ns = 1;
            end else if (m_state == 3) begin
                if (m_freq == 0) ns = 4;
                else if (tick) nf = m_freq - 1;
            end else if (m_state == 4) begin
                if (m_dead >= DT - 1) ns = 0;
            end else begin
                if (m_cool >= CD - 1 && fault_clr && !run) ns = 0;
            end
            na = (m_freq == 0) ? 0 : BOOST + (m_freq << SHIFT);
            if (na > 4095) na = 4095;
            if (moving && noc >= OCN) begin ns = 5; nf = 0; end
            if (ns == 5) na = 0;
            m_pre  = (ns == m_state && (ns == 1 || ns == 3)) ? (tick ? 0 : m_pre + 1) : 0;
            m_dead = (m_state == 4 && ns == 4) ? m_dead + 1 : 0;
            m_cool = (m_state == 5) ? ((m_cool + 1 > CD) ? CD : m_cool + 1) : 0;
            m_oc   = noc;
            m_latd = int'(adc_latch);
            m_state = ns;
            m_freq  = nf;
            m_amp   = na;
        end
    end

    always @(negedge clk) begin
        logic [32:0] ev, av;
        bit en;
        if (chk_en) begin
            en = (m_state >= 1 && m_state <= 3);
            ev = {m_state[2:0], en, en && m_dir == 0, en && m_dir == 1,
                  m_freq[11:0], m_amp[11:0], m_state == 5, m_state == 2};
            av = {state, enable, cw, ccw, frequency, amplitude, fault, at_speed};
            check($sformatf("model@%0t", $time), 64'(av), 64'(ev));
        end
    end

    typedef struct {
        bit run; bit dir; int tgt; int div; int cyc;
        int st; int f; int amp; bit en; bit cw; bit ccw; bit ats;
    } vec_t;
    vec_t tbl[17];

    task automatic pulse(input int value);
        adc = 12'(value);
        adc_latch = 1'b1;
        @(negedge clk);
        adc_latch = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_fault_outputs(input string tag);
        check({tag, "_state"}, 64'(state), 64'd5);
        check({tag, "_fault"}, 64'(fault), 64'd1);
        check({tag, "_drive"}, 64'({enable, cw, ccw}), 64'd0);
        check({tag, "_freq"}, 64'(frequency), 64'd0);
        check({tag, "_amp"}, 64'(amplitude), 64'd0);
    endtask

    initial begin
        //           run dir tgt div  cyc  st  f  amp  en cw ccw ats
        tbl[0]  = '{1, 0, 10, 2,   1,  1,  0,  0, 1, 1, 0, 0};
        tbl[1]  = '{1, 0, 10, 2,  19,  1,  9, 73, 1, 1, 0, 0};
        tbl[2]  = '{1, 0, 10, 2,   1,  1, 10, 73, 1, 1, 0, 0};
        tbl[3]  = '{1, 0, 10, 2,   1,  2, 10, 74, 1, 1, 0, 1};
        tbl[4]  = '{1, 0,  6, 2,   1,  1, 10, 74, 1, 1, 0, 0};
        tbl[5]  = '{1, 0,  6, 2,   8,  1,  6, 71, 1, 1, 0, 0};
        tbl[6]  = '{1, 0,  6, 2,   1,  2,  6, 70, 1, 1, 0, 1};
        tbl[7]  = '{1, 0, 10, 2,   1,  1,  6, 70, 1, 1, 0, 0};
        tbl[8]  = '{1, 0, 10, 2,   9,  2, 10, 74, 1, 1, 0, 1};
        tbl[9]  = '{1, 1, 10, 2,   1,  3, 10, 74, 1, 1, 0, 0};
        tbl[10] = '{1, 1, 10, 2,  20,  3,  0, 65, 1, 1, 0, 0};
        tbl[11] = '{1, 1, 10, 2,   1,  4,  0,  0, 0, 0, 0, 0};
        tbl[12] = '{1, 1, 10, 2, 999,  4,  0,  0, 0, 0, 0, 0};
        tbl[13] = '{1, 1, 10, 2,   1,  0,  0,  0, 0, 0, 0, 0};
        tbl[14] = '{1, 1, 10, 2,   1,  1,  0,  0, 1, 0, 1, 0};
        tbl[15] = '{1, 1, 10, 2,  20,  1, 10, 73, 1, 0, 1, 0};
        tbl[16] = '{1, 1, 10, 2,   1,  2, 10, 74, 1, 0, 1, 1};

        reset_n = 1'b0; run = 1'b0; dir_req = 1'b0; freq_target = '0; ramp_div = '0;
        adc = '0; adc_cmp = 12'd3000; adc_latch = 1'b0; fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_state", 64'(state), 64'd0);
        check("reset_outs", 64'({enable, cw, ccw, fault, at_speed}), 64'd0);
        check("reset_freq_amp", 64'({frequency, amplitude}), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run = tbl[i].run; dir_req = tbl[i].dir;
            freq_target = 12'(tbl[i].tgt); ramp_div = 16'(tbl[i].div);
            repeat (tbl[i].cyc) @(negedge clk);
            check($sformatf("vec%0d_state", i), 64'(state), 64'(tbl[i].st));
            check($sformatf("vec%0d_freq", i), 64'(frequency), 64'(tbl[i].f));
            check($sformatf("vec%0d_amp", i), 64'(amplitude), 64'(tbl[i].amp));
            check($sformatf("vec%0d_drive", i), 64'({enable, cw, ccw}),
                  64'({tbl[i].en, tbl[i].cw, tbl[i].ccw}));
            check($sformatf("vec%0d_at_speed", i), 64'(at_speed), 64'(tbl[i].ats));
        end

        // Overcurrent counter: non-consecutive, equal-to-threshold and held strobe do not trip
        repeat (3) pulse(4000);
        pulse(1000);
        check("oc_reset_low", 64'(state), 64'd2);
        repeat (3) pulse(4000);
        pulse(3000);
        check("oc_reset_equal", 64'(state), 64'd2);
        adc = 12'd4000; adc_latch = 1'b1;
        repeat (6) @(negedge clk);
        adc_latch = 1'b0;
        @(negedge clk);
        repeat (2) pulse(4000);
        check("oc_held_strobe", 64'(state), 64'd2);
        adc_latch = 1'b1;
        @(negedge clk);
        check_fault_outputs("oc_trip");
        adc_latch = 1'b0;

        // Fault exit blocked while run stays high
        fault_clr = 1'b1;
        repeat (CD + 20) @(negedge clk);
        check("fault_run_high", 64'(state), 64'd5);
        run = 1'b0;
        @(negedge clk);
        check("fault_exit_run_low", 64'(state), 64'd0);
        fault_clr = 1'b0;

        // Second episode: early clear ignored, exit exactly after COOLDOWN cycles
        run = 1'b1;
        repeat (25) @(negedge clk);
        check("rerun_state", 64'(state), 64'd2);
        check("rerun_ccw", 64'({cw, ccw}), 64'd1);
        repeat (3) pulse(4000);
        adc_latch = 1'b1;
        @(negedge clk);
        check_fault_outputs("oc_trip2");
        adc_latch = 1'b0; run = 1'b0; fault_clr = 1'b1;
        repeat (3) @(negedge clk);
        check("early_clr_ignored", 64'(state), 64'd5);
        fault_clr = 1'b0;
        repeat (CD - 6) @(negedge clk);
        fault_clr = 1'b1;
        repeat (2) @(negedge clk);
        check("cooldown_last", 64'(state), 64'd5);
        @(negedge clk);
        check("cooldown_exit", 64'(state), 64'd0);
        fault_clr = 1'b0;

        // ramp_div=0 steps every clock, tops out at 4095 and saturates amplitude
        run = 1'b1; dir_req = 1'b0; freq_target = 12'd4095; ramp_div = 16'd0;
        @(negedge clk);
        check("fast_enter", 64'({state, enable, cw}), 64'({3'd1, 1'b1, 1'b1}));
        repeat (4031) @(negedge clk);
        check("fast_f4031", 64'({frequency, amplitude}), 64'({12'd4031, 12'd4094}));
        @(negedge clk);
        check("fast_sat", 64'({frequency, amplitude}), 64'({12'd4032, 12'd4095}));
        repeat (64) @(negedge clk);
        check("fast_top_state", 64'(state), 64'd2);
        check("fast_top", 64'({frequency, amplitude}), 64'({12'd4095, 12'd4095}));
        repeat (5) @(negedge clk);
        check("fast_no_wrap", 64'(frequency), 64'd4095);
        reset_n = 1'b0; run = 1'b0;
        @(negedge clk);
        check("reset_abort", 64'({state, enable, frequency, amplitude}), 64'd0);
        reset_n = 1'b1;

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 20000; c++) begin
            if ($urandom_range(0, 199) == 0) run = ~run;
            if ($urandom_range(0, 299) == 0) dir_req = ~dir_req;
            if ($urandom_range(0, 119) == 0)
                freq_target = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 30));
            if ($urandom_range(0, 99) == 0) ramp_div = 16'($urandom_range(0, 3));
            adc       = 12'($urandom_range(2000, 4095));
            adc_latch = ($urandom_range(0, 3) == 0);
            fault_clr = ($urandom_range(0, 49) == 0);
            reset_n   = ($urandom_range(0, 7999) != 0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
